// File: rtl/pipe_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard_pkg
// Shared constants for the pipeline hazard/forwarding scoreboard.
//   STG_*  : stage index of an in-flight instruction (1 = EX, 2 = MEM, 3 = WB).
//   RDY_*  : stage at which an instruction's result first exists.
// No ports; imported by the scoreboard RTL and its bench.
// -----------------------------------------------------------------------------
package pipe_scoreboard_pkg;

  localparam int unsigned STG_EX   = 1;
  localparam int unsigned STG_MEM  = 2;
  localparam int unsigned STG_WB   = 3;

  localparam int unsigned RDY_ALU  = 1;
  localparam int unsigned RDY_LOAD = 2;

endpackage : pipe_scoreboard_pkg

// File: rtl/pipe_sb_lookup.sv
// -----------------------------------------------------------------------------
// pipe_sb_lookup
// Resolves one ID source operand against the in-flight scoreboard.
// The youngest matching producer (lowest stage index) wins; if its result
// already exists the operand is forwarded from that stage, otherwise the
// source is reported pending. Register 0 and unread sources always take the
// register-file value.
// Ports:
//   i_src       source register index
//   i_re        source is actually read
//   i_v         entry valid bits, bit k-1 = stage k
//   i_rd        entry destination indices, stage k at [(k-1)*AW +: AW]
//   i_rdy       entry ready stages, stage k at [(k-1)*RW +: RW]
//   i_stage_res per-stage results, stage k at [(k-1)*XLEN +: XLEN]
//   i_rf        register-file read data for this source
//   o_op        resolved operand
//   o_pending   producer found but its result does not exist yet
// -----------------------------------------------------------------------------
module pipe_sb_lookup #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int RW    = $clog2(DEPTH + 1)
) (
  input  logic [AW-1:0]         i_src,
  input  logic                  i_re,
  input  logic [DEPTH-1:0]      i_v,
  input  logic [DEPTH*AW-1:0]   i_rd,
  input  logic [DEPTH*RW-1:0]   i_rdy,
  input  logic [DEPTH*XLEN-1:0] i_stage_res,
  input  logic [XLEN-1:0]       i_rf,
  output logic [XLEN-1:0]       o_op,
  output logic                  o_pending
);

  logic w_found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    o_op      = i_rf;
    o_pending = 1'b0;
    w_found   = 1'b0;
    if (i_re && (i_src != '0)) begin
      // Walk from EX outward; the first hit is the youngest producer.
      for (int k = 0; k < DEPTH; k++) begin
        if (!w_found && i_v[k] && (i_rd[k*AW +: AW] == i_src)) begin
          w_found = 1'b1;
          if (RW'(k + 1) >= i_rdy[k*RW +: RW]) begin
            o_op = i_stage_res[k*XLEN +: XLEN];
          end else begin
            o_pending = 1'b1;
          end
        end
      end
    end
  end

endmodule : pipe_sb_lookup

// File: rtl/pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard
// Hazard and forwarding controller beside the ID stage. A DEPTH-entry
// scoreboard of {valid, rd, ready-stage} shifts in step with the pipeline
// registers; each ID source is resolved to its youngest in-flight producer,
// a stall is raised when that result does not exist yet, and stalls and EX
// redirects turn the instruction entering EX into a bubble.
// Ports:
//   cpu_clk, cpu_rst      clock, synchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_rs1/2, id_re1/2    source indices and read enables
//   id_rf1/2              register-file read data
//   id_rd, id_we, id_rdy  destination, write enable, ready stage
//   ex_redirect           taken branch/jump resolved in EX
//   stage_res             current result per stage, stage k at (k-1)*XLEN
//   op1, op2              forwarded operands
//   stall, flush, bubble  hazard controls
//   stall_cnt, flush_cnt  saturating event counters
// -----------------------------------------------------------------------------
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int RW    = $clog2(DEPTH + 1),
  parameter int CW    = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  id_valid,
  input  logic [AW-1:0]         id_rs1,
  input  logic [AW-1:0]         id_rs2,
  input  logic                  id_re1,
  input  logic                  id_re2,
  input  logic [XLEN-1:0]       id_rf1,
  input  logic [XLEN-1:0]       id_rf2,
  input  logic [AW-1:0]         id_rd,
  input  logic                  id_we,
  input  logic [RW-1:0]         id_rdy,
  input  logic                  ex_redirect,
  input  logic [DEPTH*XLEN-1:0] stage_res,
  output logic [XLEN-1:0]       op1,
  output logic [XLEN-1:0]       op2,
  output logic                  stall,
  output logic                  flush,
  output logic                  bubble,
  output logic [CW-1:0]         stall_cnt,
  output logic [CW-1:0]         flush_cnt
);

  // Entry for stage k lives at bit/slice k-1; stage 1 (EX) is the lowest.
  localparam int unsigned ENTRY_IN = STG_EX - 1;

  logic [DEPTH-1:0]      r_v;
  logic [DEPTH*AW-1:0]   r_rd;
  logic [DEPTH*RW-1:0]   r_rdy;
  logic [CW-1:0]         r_stall_cnt;
  logic [CW-1:0]         r_flush_cnt;

  logic                  w_pend1;
  logic                  w_pend2;
  logic                  w_stall;
  logic                  w_bubble;
  logic                  w_enter_v;

  pipe_sb_lookup #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .RW(RW)) u_lookup1 (
    .i_src       (id_rs1),
    .i_re        (id_re1),
    .i_v         (r_v),
    .i_rd        (r_rd),
    .i_rdy       (r_rdy),
    .i_stage_res (stage_res),
    .i_rf        (id_rf1),
    .o_op        (op1),
    .o_pending   (w_pend1)
  );

  pipe_sb_lookup #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .RW(RW)) u_lookup2 (
    .i_src       (id_rs2),
    .i_re        (id_re2),
    .i_v         (r_v),
    .i_rd        (r_rd),
    .i_rdy       (r_rdy),
    .i_stage_res (stage_res),
    .i_rf        (id_rf2),
    .o_op        (op2),
    .o_pending   (w_pend2)
  );

  // A redirect kills the ID instruction, so it never stalls on its operands.
  assign w_stall   = id_valid && (w_pend1 || w_pend2) && !ex_redirect;
  assign w_bubble  = w_stall || ex_redirect || !id_valid;
  assign w_enter_v = !w_bubble && id_we;

  assign stall     = w_stall;
  assign bubble    = w_bubble;
  assign flush     = ex_redirect;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value, independent of statement order.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_v <= '0;
    end else begin
      r_v <= {r_v[DEPTH-2:0], 1'b0};
      r_v[ENTRY_IN] <= w_enter_v;
    end
  end

  // NOTE: the rd/rdy payload is deliberately not reset; it is ignored
  // whenever the matching valid bit is clear, so resetting it buys nothing.
  always_ff @(posedge cpu_clk) begin
    r_rd  <= {r_rd[(DEPTH-1)*AW-1:0], id_rd};
    r_rdy <= {r_rdy[(DEPTH-1)*RW-1:0], id_rdy};
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CW'(1);
      end
      if (ex_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CW'(1);
      end
    end
  end

endmodule : pipe_scoreboard

// File: tb/tb_pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipe_scoreboard
// Directed scenarios plus randomized traffic against a queue-of-records
// reference model of the in-flight scoreboard. Counters use a narrow width so
// saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipe_scoreboard;
  import pipe_scoreboard_pkg::*;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int RW    = $clog2(DEPTH + 1);
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic                  cpu_clk = 1'b0;
  logic                  cpu_rst;
  logic                  id_valid;
  logic [AW-1:0]         id_rs1, id_rs2, id_rd;
  logic                  id_re1, id_re2, id_we;
  logic [XLEN-1:0]       id_rf1, id_rf2;
  logic [RW-1:0]         id_rdy;
  logic                  ex_redirect;
  logic [DEPTH*XLEN-1:0] stage_res;
  logic [XLEN-1:0]       op1, op2;
  logic                  stall, flush, bubble;
  logic [CW-1:0]         stall_cnt, flush_cnt;

  pipe_scoreboard #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .RW(RW), .CW(CW)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_re1      (id_re1),
    .id_re2      (id_re2),
    .id_rf1      (id_rf1),
    .id_rf2      (id_rf2),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_rdy      (id_rdy),
    .ex_redirect (ex_redirect),
    .stage_res   (stage_res),
    .op1         (op1),
    .op2         (op2),
    .stall       (stall),
    .flush       (flush),
    .bubble      (bubble),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    int rd;
    int rdy;
  } ent_t;

  ent_t sb [1:DEPTH];
  int   m_stall_cnt;
  int   m_flush_cnt;

  logic [XLEN-1:0] e_op1, e_op2;
  logic            e_stall, e_bubble, e_flush;

  int total = 0;
  int bad   = 0;

  function automatic logic [XLEN-1:0] res_of(input int k);
    return stage_res[(k-1)*XLEN +: XLEN];
  endfunction

  // Youngest matching producer decides; its result exists once k >= rdy.
  task automatic resolve(input int s, input bit re, input logic [XLEN-1:0] rf,
                         output logic [XLEN-1:0] op, output bit pend);
    bit done;
    op   = rf;
    pend = 1'b0;
    done = 1'b0;
    if (re && s != 0) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (!done && sb[k].v && sb[k].rd == s) begin
          done = 1'b1;
          if (k >= sb[k].rdy) op = res_of(k);
          else pend = 1'b1;
        end
      end
    end
  endtask

  task automatic model_eval();
    bit p1, p2;
    resolve(int'(id_rs1), id_re1, id_rf1, e_op1, p1);
    resolve(int'(id_rs2), id_re2, id_rf2, e_op2, p2);
    e_stall  = id_valid && (p1 || p2) && !ex_redirect;
    e_flush  = ex_redirect;
    e_bubble = e_stall || ex_redirect || !id_valid;
  endtask

  // Advance one clock: evaluate the model on current inputs, then update it.
  task automatic tick();
    model_eval();
    @(posedge cpu_clk);
    if (cpu_rst) begin
      for (int k = 1; k <= DEPTH; k++) sb[k].v = 1'b0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) sb[k] = sb[k-1];
      if (e_bubble) sb[1] = '{v: 1'b0, rd: 0, rdy: 0};
      else          sb[1] = '{v: id_we, rd: int'(id_rd), rdy: int'(id_rdy)};
      if (e_stall && m_stall_cnt < CMAX) m_stall_cnt++;
      if (e_flush && m_flush_cnt < CMAX) m_flush_cnt++;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit re1, input int rs2,
                       input bit re2, input int rd, input bit we, input int rdy,
                       input bit redir);
    id_valid    = v;
    id_rs1      = AW'(rs1);
    id_re1      = re1;
    id_rs2      = AW'(rs2);
    id_re2      = re2;
    id_rf1      = 32'hA000_0000 | XLEN'(rs1);
    id_rf2      = 32'hB000_0000 | XLEN'(rs2);
    id_rd       = AW'(rd);
    id_we       = we;
    id_rdy      = RW'(rdy);
    ex_redirect = redir;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, RDY_ALU, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cpu_rst   = 1'b1;
    stage_res = '0;
    idle(2);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (bubble !== 1'b1) begin bad++; $display("FAIL reset_bubble got=%b exp=1", bubble); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    total++; if (flush_cnt !== '0) begin bad++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle(DEPTH);
    drive(1, 0, 1, 0, 0, 5, 1, RDY_ALU, 0);           // addi x5,x0,7
    tick();
    drive(1, 5, 1, 5, 1, 6, 1, RDY_ALU, 0);           // add x6,x5,x5
    stage_res = {32'h0, 32'h0, 32'd7};
    @(negedge cpu_clk);
    total++; if (op1 !== 32'd7) begin bad++; $display("FAIL b2b_op1 got=%h exp=7", op1); end
    total++; if (op2 !== 32'd7) begin bad++; $display("FAIL b2b_op2 got=%h exp=7", op2); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_load_use();
    idle(DEPTH);
    drive(1, 0, 0, 0, 0, 7, 1, RDY_LOAD, 0);          // lw x7
    tick();
    drive(1, 7, 1, 0, 1, 8, 1, RDY_ALU, 0);           // add x8,x7,x0
    stage_res = {32'h0, 32'h1234, 32'hDEAD};
    @(negedge cpu_clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
    total++; if (bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%b exp=1", bubble); end
    tick();
    @(negedge cpu_clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall2 got=%b exp=0", stall); end
    total++; if (op1 !== res_of(STG_MEM)) begin bad++; $display("FAIL lu_op1 got=%h exp=%h", op1, res_of(STG_MEM)); end
    total++; if (op2 !== id_rf2) begin bad++; $display("FAIL lu_op2 got=%h exp=%h", op2, id_rf2); end
    total++; if (int'(stall_cnt) !== m_stall_cnt) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, m_stall_cnt); end
    tick();
  endtask

  task automatic test_youngest();
    idle(DEPTH);
    drive(1, 0, 0, 0, 0, 5, 1, RDY_ALU, 0);
    tick();
    drive(1, 0, 0, 0, 0, 5, 1, RDY_ALU, 0);
    tick();
    drive(1, 5, 1, 0, 0, 9, 1, RDY_ALU, 0);
    stage_res = {32'h0, 32'hB, 32'hA};
    @(negedge cpu_clk);
    total++; if (op1 !== 32'hA) begin bad++; $display("FAIL young_op1 got=%h exp=a", op1); end
    tick();
  endtask

  task automatic test_zero_reg();
    idle(DEPTH);
    drive(1, 0, 0, 0, 0, 0, 1, RDY_LOAD, 0);          // load into x0
    tick();
    drive(1, 0, 0, 0, 0, 9, 1, RDY_LOAD, 0);          // lw x9
    tick();
    drive(1, 0, 1, 9, 0, 10, 1, RDY_ALU, 0);          // reads x0, x9 unread
    stage_res = {32'h3, 32'h2, 32'h1};
    @(negedge cpu_clk);
    total++; if (op1 !== id_rf1) begin bad++; $display("FAIL zero_op1 got=%h exp=%h", op1, id_rf1); end
    total++; if (op2 !== id_rf2) begin bad++; $display("FAIL zero_op2 got=%h exp=%h", op2, id_rf2); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_redirect();
    int f0;
    idle(DEPTH);
    drive(1, 0, 0, 0, 0, 10, 1, RDY_LOAD, 0);         // lw x10
    tick();
    f0 = m_flush_cnt;
    drive(1, 10, 1, 0, 0, 11, 1, RDY_ALU, 1);         // dependent, redirected
    @(negedge cpu_clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL redir_stall got=%b exp=0", stall); end
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL redir_flush got=%b exp=1", flush); end
    total++; if (bubble !== 1'b1) begin bad++; $display("FAIL redir_bubble got=%b exp=1", bubble); end
    tick();
    drive(1, 11, 1, 0, 0, 12, 1, RDY_ALU, 0);         // killed x11 must not forward
    stage_res = {32'h33, 32'h22, 32'h11};
    @(negedge cpu_clk);
    total++; if (int'(flush_cnt) !== f0 + 1) begin bad++; $display("FAIL redir_flush_cnt got=%0d exp=%0d", flush_cnt, f0 + 1); end
    total++; if (op1 !== id_rf1) begin bad++; $display("FAIL redir_killed_op1 got=%h exp=%h", op1, id_rf1); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    idle(DEPTH);
    drive(1, 0, 0, 0, 0, 12, 1, RDY_LOAD, 0);
    tick();
    drive(1, 12, 1, 0, 0, 13, 1, RDY_ALU, 0);
    @(negedge cpu_clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall got=%b exp=1", stall); end
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_post_stall got=%b exp=0", stall); end
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL rst_post_stall_cnt got=%0d exp=0", stall_cnt); end
    total++; if (flush_cnt !== '0) begin bad++; $display("FAIL rst_post_flush_cnt got=%0d exp=0", flush_cnt); end
    tick();
    // Drive the stall counter into saturation.
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(1, 0, 0, 0, 0, 12, 1, RDY_LOAD, 0);
      tick();
      drive(1, 12, 1, 0, 0, 13, 1, RDY_ALU, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 12, 1, RDY_LOAD, 0);
    tick();
    drive(1, 12, 1, 0, 0, 13, 1, RDY_ALU, 0);
    @(negedge cpu_clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_stall got=%b exp=1", stall); end
    total++; if (int'(stall_cnt) !== CMAX) begin bad++; $display("FAIL sat_cnt_pre got=%0d exp=%0d", stall_cnt, CMAX); end
    tick();
    @(negedge cpu_clk);
    total++; if (int'(stall_cnt) !== CMAX) begin bad++; $display("FAIL sat_cnt_hold got=%0d exp=%0d", stall_cnt, CMAX); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cpu_rst = ($urandom_range(63) == 0);
      drive($urandom_range(3) != 0, int'($urandom_range(3)), 1'($urandom_range(1)),
            int'($urandom_range(3)), 1'($urandom_range(1)), int'($urandom_range(3)),
            1'($urandom_range(1)), int'($urandom_range(DEPTH, 1)),
            $urandom_range(7) == 0);
      stage_res = {$urandom, $urandom, $urandom};
      @(negedge cpu_clk);
      model_eval();
      total++; if (op1 !== e_op1) begin bad++; $display("FAIL rand_op1 i=%0d got=%h exp=%h", i, op1, e_op1); end
      total++; if (op2 !== e_op2) begin bad++; $display("FAIL rand_op2 i=%0d got=%h exp=%h", i, op2, e_op2); end
      total++; if (stall !== e_stall) begin bad++; $display("FAIL rand_stall i=%0d got=%b exp=%b", i, stall, e_stall); end
      total++; if (bubble !== e_bubble) begin bad++; $display("FAIL rand_bubble i=%0d got=%b exp=%b", i, bubble, e_bubble); end
      total++; if (flush !== e_flush) begin bad++; $display("FAIL rand_flush i=%0d got=%b exp=%b", i, flush, e_flush); end
      total++; if (int'(stall_cnt) !== m_stall_cnt) begin bad++; $display("FAIL rand_stall_cnt i=%0d got=%0d exp=%0d", i, stall_cnt, m_stall_cnt); end
      total++; if (int'(flush_cnt) !== m_flush_cnt) begin bad++; $display("FAIL rand_flush_cnt i=%0d got=%0d exp=%0d", i, flush_cnt, m_flush_cnt); end
      tick();
    end
    cpu_rst = 1'b0;
  endtask

  initial begin
    for (int k = 1; k <= DEPTH; k++) sb[k] = '{v: 1'b0, rd: 0, rdy: 0};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    cpu_rst     = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, RDY_ALU, 0);
    stage_res   = '0;
    #1;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_redirect();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_scoreboard
